// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Iterative shift-and-add-3 (double-dabble) binary to packed BCD converter.
// One input bit is consumed per clock, so the combinational path is only one
// 4-bit "add 3" per digit. A conversion takes W+2 cycles from start to the
// next accepted start.
//
// Optional feature macro: BIN2BCD_BLANK_EN
//   When defined, adds blank_mask, which flags leading-zero digits so the
//   display driver can blank them. Digit 0 is never blanked.
//
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   start      in   conversion request, sampled only while idle
//   bin        in   [W-1:0] unsigned binary value, sampled on the accepting edge
//   busy       out  high while a conversion is in progress
//   done       out  one-cycle pulse; bcd carries the new result from then on
//   bcd        out  [4*DIGITS-1:0] packed BCD, digit 0 in [3:0]
//   blank_mask out  [DIGITS-1:0] 1 = leading-zero digit (BIN2BCD_BLANK_EN only)
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
   parameter int W      = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [W-1:0]          bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank_mask
`endif
);

   localparam int CNT_W = $clog2(W + 1);
   localparam int BW    = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_FINISH
   } state_t;

   // Add 3 to every digit that is 5 or more, so the following left shift
   // carries correctly into the next decimal digit.
   function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] s);
      logic [BW-1:0] r;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (s[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = s[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

`ifdef BIN2BCD_BLANK_EN
   localparam logic [DIGITS-1:0] MASK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   // Bit i is set when digit i and every digit above it are zero; bit 0 stays
   // clear so a zero result still shows a single "0".
   function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [BW-1:0] s);
      logic [DIGITS-1:0] m;
      logic              z;
      m = '0;
      z = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         z    = z & (s[4*i +: 4] == 4'd0);
         m[i] = z;
      end
      return m;
   endfunction

   logic [DIGITS-1:0] r_blank_mask;
   assign blank_mask = r_blank_mask;
`endif

   state_t            r_state;
   logic [W-1:0]      r_shift;
   logic [BW-1:0]     r_scratch;
   logic [CNT_W-1:0]  r_count;
   logic              r_busy;
   logic              r_done;
   logic [BW-1:0]     r_bcd;

   logic [BW-1:0]     w_adj;

   assign w_adj = dabble_adjust(r_scratch);

   assign busy  = r_busy;
   assign done  = r_done;
   assign bcd   = r_bcd;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_scratch <= '0;
         r_count   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_bcd     <= '0;
`ifdef BIN2BCD_BLANK_EN
         r_blank_mask <= MASK_RST;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_shift   <= bin;
                  r_scratch <= '0;
                  r_count   <= CNT_W'(W);
                  r_busy    <= 1'b1;
                  r_state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // Adjust first, then shift the next binary MSB into digit 0.
               r_scratch <= {w_adj[BW-2:0], r_shift[W-1]};
               r_shift   <= {r_shift[W-2:0], 1'b0};
               r_count   <= r_count - CNT_W'(1);
               if (r_count == CNT_W'(1)) begin
                  r_state <= S_FINISH;
               end
            end
            S_FINISH: begin
               r_bcd   <= r_scratch;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
`ifdef BIN2BCD_BLANK_EN
               r_blank_mask <= lead_zero_mask(r_scratch);
`endif
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

   logic        clk;
   logic        resetn;
   logic        start;
   logic [15:0] bin;
   logic        busy;
   logic        done;
   logic [19:0] bcd;
`ifdef BIN2BCD_BLANK_EN
   logic [4:0]  blank_mask;
`endif

   int errors;
   int checks;

   bin2bcd_seq #(.W(16), .DIGITS(5)) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .bin    (bin),
      .busy   (busy),
      .done   (done),
      .bcd    (bcd)
`ifdef BIN2BCD_BLANK_EN
      ,
      .blank_mask (blank_mask)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one conversion (start sampled at "edge 0") and observes 25 cycles.
   // lat = number of edges after edge 0 until done is seen (-1 if never).
   task automatic run_conv(input logic [15:0] v, output int lat,
                           output int busy_cnt, output int done_cnt);
      lat = -1; busy_cnt = 0; done_cnt = 0;
      @(negedge clk);
      start = 1'b1; bin = v;
      @(negedge clk);            // edge 0 has passed
      start = 1'b0; bin = 16'hA5A5;
      for (int k = 0; k < 25; k++) begin
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            if (lat < 0) lat = k;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0; start = 1'b0; bin = 16'h0000;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (bcd !== 20'h00000) begin errors++; $display("FAIL reset_bcd got=%h exp=00000", bcd); end
`ifdef BIN2BCD_BLANK_EN
      checks++; if (blank_mask !== 5'b11110) begin errors++; $display("FAIL reset_mask got=%b exp=11110", blank_mask); end
`endif
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_convert;
      logic [15:0] vin [4];
      logic [19:0] vexp [4];
      int lat, bc, dc;
      vin[0] = 16'h0000; vexp[0] = 20'h00000;
      vin[1] = 16'hFFFF; vexp[1] = 20'h65535;
      vin[2] = 16'hDEAD; vexp[2] = 20'h57005;
      vin[3] = 16'hFE01; vexp[3] = 20'h65025;
      for (int i = 0; i < 4; i++) begin
         run_conv(vin[i], lat, bc, dc);
         checks++; if (bcd !== vexp[i]) begin errors++; $display("FAIL conv_bcd[%0d] got=%h exp=%h", i, bcd, vexp[i]); end
         checks++; if (lat !== 17) begin errors++; $display("FAIL conv_latency[%0d] got=%0d exp=17", i, lat); end
         checks++; if (bc !== 17) begin errors++; $display("FAIL conv_busy_cycles[%0d] got=%0d exp=17", i, bc); end
         checks++; if (dc !== 1) begin errors++; $display("FAIL conv_done_count[%0d] got=%0d exp=1", i, dc); end
      end
   endtask

   task automatic test_start_ignored;
      int lat, bc, dc;
      lat = -1; bc = 0; dc = 0;
      @(negedge clk);
      start = 1'b1; bin = 16'h1234;
      @(negedge clk);            // edge 0
      start = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (busy === 1'b1) bc++;
         if (done === 1'b1) begin dc++; if (lat < 0) lat = k; end
         // start sampled at edges 5 (SHIFT) and 17 (FINISH)
         start = (k == 4 || k == 16);
         bin   = start ? 16'h0001 : 16'h1234;
         @(negedge clk);
      end
      start = 1'b0;
      checks++; if (bcd !== 20'h04660) begin errors++; $display("FAIL ignore_bcd got=%h exp=04660", bcd); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dc); end
      checks++; if (lat !== 17) begin errors++; $display("FAIL ignore_latency got=%0d exp=17", lat); end
      checks++; if (bc !== 17) begin errors++; $display("FAIL ignore_busy_cycles got=%0d exp=17", bc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_reset_abort;
      int lat, bc, dc;
      int seen;
      seen = 0;
      @(negedge clk);
      start = 1'b1; bin = 16'h9999;
      @(negedge clk);            // edge 0
      start = 1'b0;
      repeat (7) @(negedge clk); // after edge 7
      resetn = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
      checks++; if (bcd !== 20'h00000) begin errors++; $display("FAIL abort_bcd got=%h exp=00000", bcd); end
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (done === 1'b1 || busy === 1'b1) seen++;
         @(negedge clk);
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_resume got=%0d exp=0", seen); end
      run_conv(16'h0007, lat, bc, dc);
      checks++; if (bcd !== 20'h00007) begin errors++; $display("FAIL abort_after_bcd got=%h exp=00007", bcd); end
      checks++; if (lat !== 17) begin errors++; $display("FAIL abort_after_latency got=%0d exp=17", lat); end
   endtask

`ifdef BIN2BCD_BLANK_EN
   task automatic test_blank;
      int lat, bc, dc;
      run_conv(16'h0042, lat, bc, dc);
      checks++; if (bcd !== 20'h00066) begin errors++; $display("FAIL blank_bcd_66 got=%h exp=00066", bcd); end
      checks++; if (blank_mask !== 5'b11100) begin errors++; $display("FAIL blank_mask_66 got=%b exp=11100", blank_mask); end
      run_conv(16'h0000, lat, bc, dc);
      checks++; if (blank_mask !== 5'b11110) begin errors++; $display("FAIL blank_mask_0 got=%b exp=11110", blank_mask); end
      run_conv(16'h2710, lat, bc, dc);
      checks++; if (bcd !== 20'h10000) begin errors++; $display("FAIL blank_bcd_10000 got=%h exp=10000", bcd); end
      checks++; if (blank_mask !== 5'b00000) begin errors++; $display("FAIL blank_mask_10000 got=%b exp=00000", blank_mask); end
   endtask
`endif

   task automatic test_back_to_back;
      int n_done;
      int last_k;
      logic [19:0] exp_bcd;
      n_done = 0; last_k = -1;
      @(negedge clk);
      start = 1'b1; bin = 16'h000A;
      for (int k = -1; k < 75; k++) begin
         @(negedge clk);        // edge k+1 has passed; loop index k+1 used below
         if (done === 1'b1) begin
            exp_bcd = (n_done % 2 == 0) ? 20'h00010 : 20'h00100;
            checks++; if (bcd !== exp_bcd) begin errors++; $display("FAIL b2b_bcd[%0d] got=%h exp=%h", n_done, bcd, exp_bcd); end
            if (last_k >= 0) begin
               checks++; if ((k + 1 - last_k) !== 18) begin errors++; $display("FAIL b2b_interval[%0d] got=%0d exp=18", n_done, k + 1 - last_k); end
            end
            last_k = k + 1;
            n_done++;
            // next accepting edge follows immediately; present the other value
            bin = (bin == 16'h000A) ? 16'h0064 : 16'h000A;
         end
      end
      start = 1'b0;
      checks++; if (n_done !== 4) begin errors++; $display("FAIL b2b_done_count got=%0d exp=4", n_done); end
      repeat (20) @(negedge clk);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_convert();
      test_start_ignored();
      test_reset_abort();
`ifdef BIN2BCD_BLANK_EN
      test_blank();
`endif
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
